// File: rtl/qmath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qmath_pkg
//  Description : Shared fixed-point math definitions: default word format,
//                divider state encoding, saturation limits, counter sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package qmath_pkg;

    localparam int N_DEFAULT = 32;
    localparam int Q_DEFAULT = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturation limits for the default word width
    localparam logic [N_DEFAULT-1:0] QMAX = {1'b0, {(N_DEFAULT-1){1'b1}}};
    localparam logic [N_DEFAULT-1:0] QMIN = {1'b1, {(N_DEFAULT-1){1'b0}}};

    // Width of a counter that indexes every quotient bit
    function automatic int cnt_width(input int n, input int q);
        return $clog2(n + q);
    endfunction

    localparam int CNT_W = cnt_width(N_DEFAULT, Q_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/qabs.sv
`default_nettype none
// ============================================================================
//  Module      : qabs
//  Description : Combinational sign/magnitude split of a two's-complement
//                word. Returns {sign, N-bit unsigned magnitude}; the most
//                negative value maps to magnitude 2^(N-1).
//  Revision    : 1.0  initial release
// ============================================================================
module qabs
    import qmath_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] i_value,
    output logic [N:0]   o_sign_mag
);

    logic w_sign;
    logic [N-1:0] w_neg;

    assign w_sign     = i_value[N-1];
    assign w_neg      = {N{1'b0}} - i_value;
    assign o_sign_mag = {w_sign, (w_sign ? w_neg : i_value)};

endmodule
`default_nettype wire

// File: rtl/qdiv.sv
`default_nettype none
// ============================================================================
//  Module      : qdiv
//  Description : Sequential signed fixed-point divider (N-bit, Q fraction
//                bits). Sign-magnitude restoring division, one quotient bit
//                per clock, with overflow and divide-by-zero flags.
//                Optional macro QDIV_SATURATE_EN: saturate the result on
//                overflow / divide-by-zero instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module qdiv
    import qmath_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int Q = Q_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovr,
    output logic         o_div0
);

    localparam int c_w     = N + Q;
    localparam int c_cnt_w = cnt_width(N, Q);

`ifdef QDIV_SATURATE_EN
    localparam logic [N-1:0] c_qmax = (N == N_DEFAULT) ? N'(QMAX) : {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_qmin = (N == N_DEFAULT) ? N'(QMIN) : {1'b1, {(N-1){1'b0}}};
`endif

    state_t r_state;
    state_t w_next_state;

    logic [N:0]         w_abs_a;
    logic [N:0]         w_abs_b;
    logic               w_start_ok;
    logic               w_b_zero;
    logic [N-1:0]       w_div0_q;

    logic               r_sign;
    logic [N-1:0]       r_div;
    logic [N-1:0]       r_rem;
    logic [c_w-1:0]     r_shq;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-1:0]       r_quot;
    logic               r_ovr;
    logic               r_div0;

    logic [N:0]         w_rem_sh;
    logic [N:0]         w_trial;
    logic               w_qbit;
    logic [N-1:0]       w_rem_nx;
    logic [c_w-1:0]     w_mag;
    logic               w_last;
    logic               w_ovr;
    logic [N-1:0]       w_wrap;
    logic [N-1:0]       w_res;

    qabs #(.N(N)) u_abs_a (.i_value(i_dividend), .o_sign_mag(w_abs_a));
    qabs #(.N(N)) u_abs_b (.i_value(i_divisor),  .o_sign_mag(w_abs_b));

    assign w_start_ok = i_start && (r_state != CALC);
    assign w_b_zero   = (w_abs_b[N-1:0] == {N{1'b0}});

    // One restoring step: shift next numerator bit in, trial-subtract divisor.
    // The remainder stays below |b| <= 2^(N-1), so N bits hold it and the
    // shifted value fits N+1 bits.
    assign w_rem_sh = {r_rem, r_shq[c_w-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};
    assign w_qbit   = ~w_trial[N];
    assign w_rem_nx = w_qbit ? w_trial[N-1:0] : w_rem_sh[N-1:0];
    assign w_mag    = {r_shq[c_w-2:0], w_qbit};
    assign w_last   = (r_state == CALC) && (r_cnt == {c_cnt_w{1'b0}});

`ifdef QDIV_SATURATE_EN
    assign w_div0_q = w_abs_a[N] ? c_qmin : c_qmax;
`else
    assign w_div0_q = {N{1'b0}};
`endif

    // Overflow detection and signed result formation from the final magnitude
    always_comb begin
        w_ovr  = (|w_mag[c_w-1:N]) |
                 (r_sign ? (w_mag[N-1] & (|w_mag[N-2:0])) : w_mag[N-1]);
        w_wrap = r_sign ? ({N{1'b0}} - w_mag[N-1:0]) : w_mag[N-1:0];
`ifdef QDIV_SATURATE_EN
        w_res  = w_ovr ? (r_sign ? c_qmin : c_qmax) : w_wrap;
`else
        w_res  = w_wrap;
`endif
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a zero divisor skips straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next_state = w_b_zero ? DONE : CALC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == {c_cnt_w{1'b0}}) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and held result/flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign <= 1'b0;
            r_div  <= {N{1'b0}};
            r_rem  <= {N{1'b0}};
            r_shq  <= {c_w{1'b0}};
            r_cnt  <= {c_cnt_w{1'b0}};
            r_quot <= {N{1'b0}};
            r_ovr  <= 1'b0;
            r_div0 <= 1'b0;
        end else if (w_start_ok) begin
            r_sign <= w_abs_a[N] ^ w_abs_b[N];
            r_div  <= w_abs_b[N-1:0];
            r_rem  <= {N{1'b0}};
            r_shq  <= {w_abs_a[N-1:0], {Q{1'b0}}};
            r_cnt  <= c_cnt_w'(N + Q - 1);
            if (w_b_zero) begin
                r_quot <= w_div0_q;
                r_ovr  <= 1'b1;
                r_div0 <= 1'b1;
            end else begin
                r_ovr  <= 1'b0;
                r_div0 <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nx;
            r_shq <= w_mag;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (w_last) begin
                r_quot <= w_res;
                r_ovr  <= w_ovr;
            end
        end
    end

    assign o_quotient = r_quot;
    assign o_ovr      = r_ovr;
    assign o_div0     = r_div0;
    assign o_busy     = (r_state == CALC);
    assign o_done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_qdiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qdiv
//  Description : Directed self-checking bench for qdiv (N=32, Q=18).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qdiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic        busy, done, ovr, div0;

    int checks = 0;
    int errors = 0;

    qdiv dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_quotient (quotient),
        .o_busy     (busy),
        .o_done     (done),
        .o_ovr      (ovr),
        .o_div0     (div0)
    );

    always #5 clk = ~clk;

`ifdef QDIV_SATURATE_EN
    localparam logic [31:0] Q_4096_OVR = 32'h7FFFFFFF;
    localparam logic [31:0] Q_POS_DIV0 = 32'h7FFFFFFF;
    localparam logic [31:0] Q_NEG_DIV0 = 32'h80000000;
    localparam logic [31:0] Q_MIN_NEG1 = 32'h7FFFFFFF;
`else
    localparam logic [31:0] Q_4096_OVR = 32'h00000000;
    localparam logic [31:0] Q_POS_DIV0 = 32'h00000000;
    localparam logic [31:0] Q_NEG_DIV0 = 32'h00000000;
    localparam logic [31:0] Q_MIN_NEG1 = 32'h80000000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one division and wait for o_done; returns in the DONE cycle.
    // poke>0 fires a start with different operands during CALC at that cycle.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_ovr, input logic exp_div0,
                          input int exp_lat, input int poke);
        int lat;
        logic busy_bad;
        busy_bad = 1'b0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (lat == poke) begin
                start    = 1'b1;
                dividend = 32'h00180000;
                divisor  = 32'h00000001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_during"}, {31'd0, busy_bad}, 32'd0);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " ovr"}, {31'd0, ovr}, {31'd0, exp_ovr});
        check({tag, " div0"}, {31'd0, div0}, {31'd0, exp_div0});
    endtask

    // One cycle after DONE: pulse over, result and flags still held
    task automatic check_hold(input string tag, input logic [31:0] exp_q,
                              input logic exp_ovr, input logic exp_div0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " hold_q"}, quotient, exp_q);
        check({tag, " hold_flags"}, {30'd0, ovr, div0}, {30'd0, exp_ovr, exp_div0});
    endtask

    initial begin
        int n_done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst quotient", quotient, 32'h0);
        check("rst flags", {28'd0, busy, done, ovr, div0}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 6.0 / 2.0 = 3.0
        do_div("6/2", 32'h00180000, 32'h00080000, 32'h000C0000, 1'b0, 1'b0, 51, 0);
        check_hold("6/2", 32'h000C0000, 1'b0, 1'b0);

        // -1.5 / 0.5 = -3.0
        do_div("-1.5/0.5", 32'hFFFA0000, 32'h00020000, 32'hFFF40000, 1'b0, 1'b0, 51, 0);

        // 1.0 / 3.0 truncated, with an ignored start mid-CALC
        do_div("1/3", 32'h00040000, 32'h000C0000, 32'h00015555, 1'b0, 1'b0, 51, 10);
        check_hold("1/3", 32'h00015555, 1'b0, 1'b0);

        // 4096.0 / 0.25 overflows (magnitude 2^32)
        do_div("4096/0.25", 32'h40000000, 32'h00010000, Q_4096_OVR, 1'b1, 1'b0, 51, 0);

        // Divide by zero, positive and negative dividend
        do_div("1/0", 32'h00040000, 32'h00000000, Q_POS_DIV0, 1'b1, 1'b1, 1, 0);
        check_hold("1/0", Q_POS_DIV0, 1'b1, 1'b1);
        do_div("-1/0", 32'hFFFC0000, 32'h00000000, Q_NEG_DIV0, 1'b1, 1'b1, 1, 0);

        // Most negative value: -2^(N-1) fits, +2^(N-1) overflows
        do_div("min/1", 32'h80000000, 32'h00040000, 32'h80000000, 1'b0, 1'b0, 51, 0);
        do_div("min/-1", 32'h80000000, 32'hFFFC0000, Q_MIN_NEG1, 1'b1, 1'b0, 51, 0);

        // Negative result truncating to zero gives +0, then back-to-back start
        do_div("-lsb/2", 32'hFFFFFFFF, 32'h00080000, 32'h00000000, 1'b0, 1'b0, 51, 0);
        do_div("b2b -6/-2", 32'hFFE80000, 32'hFFF80000, 32'h000C0000, 1'b0, 1'b0, 51, 0);
        check_hold("b2b", 32'h000C0000, 1'b0, 1'b0);

        // Reset at cycle 20 of a division: no done from the aborted op
        dividend = 32'h00040000;
        divisor  = 32'h000C0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abort busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort rst quotient", quotient, 32'h0);
        check("abort rst flags", {28'd0, busy, done, ovr, div0}, 32'h0);
        n_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check("abort no_done", 32'(n_done), 32'd0);

        do_div("post-rst -6/-2", 32'hFFE80000, 32'hFFF80000, 32'h000C0000, 1'b0, 1'b0, 51, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qdiv.md
# qdiv

Sequential signed fixed-point divider, the inverse companion to the team's combinational fixed-point multiplier. It computes dividend/divisor in the same N-bit two's-complement format with Q fraction bits, using sign-magnitude restoring division at one quotient bit per clock. It reports overflow and divide-by-zero, and it serves the Kalman gain path where a covariance term is divided by the innovation variance.

## Interface
- Q, 18, number of fraction bits.
- N, 32, total word width, sign bit included.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only when not busy.
- i_dividend  in  N  signed fixed-point dividend; captured when the start is accepted.
- i_divisor  in  N  signed fixed-point divisor; captured when the start is accepted.
- o_quotient  out  N  signed fixed-point result; held until the next accepted start.
- o_busy  out  1  high while a division is in progress.
- o_done  out  1  one-cycle pulse when o_quotient is valid.
- o_ovr  out  1  the result does not fit in N bits; held with o_quotient.
- o_div0  out  1  the divisor was zero; held with o_quotient.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE / DONE accepting a start:** i_start=1 in IDLE or DONE accepts a new operation.
  - The sign is captured as sa^sb, where sa and sb are the operand MSBs.
  - The magnitudes |a| and |b| are captured as N-bit unsigned values; |0x80000000| = 2^(N-1) is legal.
  - o_ovr and o_div0 clear.
- **Zero divisor:** if the divisor is 0, the block goes to DONE with o_div0=1 and o_ovr=1, and skips CALC.
- **Non-zero divisor:** the block goes to CALC with counter = N+Q-1.
- **CALC:**
  - The numerator is |a|<<Q (N+Q bits), shifted MSB-first into an (N+1)-bit partial remainder.
  - Each cycle: trial-subtract |b|; if the result is non-negative, keep it and shift in quotient bit 1, otherwise shift in 0.
  - When counter=0, the block goes to DONE.
- **Quotient magnitude:** N+Q bits, truncated toward zero.
- **Overflow in DONE:**
  - o_ovr=1 if the magnitude is greater than 2^(N-1)-1 when the sign is 0.
  - o_ovr=1 if the magnitude is greater than 2^(N-1) when the sign is 1.
- **Result in DONE:** o_quotient = low N bits of the magnitude, negated if the sign is 1. A zero magnitude always gives +0.
- **DONE exit:** the block stays in DONE, holding its outputs, and returns to IDLE on the next cycle unless a start is accepted.
- **Start while busy:** i_start in CALC is ignored; operand changes during CALC have no effect.
- **Reset:** i_rst at any time, including mid-CALC, forces IDLE. All outputs go to 0 and the partial result is discarded.

## Timing
- Reset values: o_quotient=0, o_busy=0, o_done=0, o_ovr=0, o_div0=0.
- **Normal latency:** start sampled at edge k.
  - o_busy=1 during cycles k+1 .. k+N+Q.
  - o_done=1 and outputs valid in cycle k+N+Q+1. With the defaults, o_done is 51 cycles after the start edge.
- **Divide-by-zero latency:** o_done is in cycle k+1; o_busy never asserts.
- **Back-to-back:** a start sampled in the DONE cycle begins the next operation immediately, giving one result every N+Q+1 cycles.
- **Done pulse:** o_done is high for exactly one cycle per accepted start.

## Configuration
- Macro: QDIV_SATURATE_EN.
- **Defined:**
  - On o_ovr, o_quotient = 0x7FFFFFFF (positive sign) or 0x80000000 (negative sign).
  - On o_div0, the saturation value follows the dividend sign; a zero dividend gives 0x7FFFFFFF.
- **Undefined:** on overflow, o_quotient wraps (low N bits, sign applied), and a zero divisor gives 0. The flags are identical in both builds.

## Structure
- Package qmath_pkg holds:
  - default N and Q;
  - the state enum (IDLE, CALC, DONE);
  - the saturation constants QMAX and QMIN;
  - the counter width, clog2(N+Q).
- One sub-module, qabs: combinational sign/magnitude extraction returning {sign, N-bit magnitude}. It is instantiated for both operands and is reusable by the multiplier.

## Test plan
- 6.0/2.0: 0x00180000 / 0x00080000 -> o_quotient 0x000C0000, ovr=0, o_done 51 cycles after start.
- -1.5/0.5: 0xFFFA0000 / 0x00020000 -> 0xFFF40000, ovr=0.
- 1.0/3.0: 0x00040000 / 0x000C0000 -> 0x00015555, truncated.
- 4096.0/0.25: 0x40000000 / 0x00010000 -> ovr=1; o_quotient 0x7FFFFFFF with QDIV_SATURATE_EN, 0x00000000 without.
- 1.0/0: 0x00040000 / 0 -> o_div0=1, ovr=1, o_done one cycle after start, o_busy stays 0.
- Reset mid-CALC at cycle 20, then a new start of -6.0/-2.0 -> no o_done from the aborted operation; the new result is 0x000C0000.
